sort_serializer: RTL and testbench



---
 rtl/sort_serializer_if.sv | 28 ++
 rtl/sort_serializer.sv | 91 +++++++++
 tb/tb_sort_serializer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_serializer_if.sv
// rtl/sort_serializer_if.sv - frame-in / word-out handshake bundle for sort_serializer
interface sort_serializer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] in4;
    logic [WIDTH-1:0] in5;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_idx;
    logic             out_last;
    logic             order_err;

    modport master (
        output in_valid, in1, in2, in3, in4, in5, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, order_err
    );

    modport slave (
        input  in_valid, in1, in2, in3, in4, in5, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, order_err
    );
endinterface

// File: rtl/sort_serializer.sv
// rtl/sort_serializer.sv - ping-pong buffered serializer for 5-word sorted frames
// Optional macro SORT_ORDER_CHECK_EN builds the sticky descending-order checker.
module sort_serializer #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    sort_serializer_if.slave  bus
);
    logic [WIDTH-1:0] frame_q [2][5];
    logic [1:0]       full_q;
    logic [1:0]       full_nxt;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [2:0]       idx_q;
    logic             accept;
    logic             pop;
    logic             pop_last;

    assign bus.in_ready  = !full_q[wr_ptr_q];
    assign bus.out_valid = full_q[rd_ptr_q];
    assign bus.out_data  = full_q[rd_ptr_q] ? frame_q[rd_ptr_q][idx_q] : '0;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = (idx_q == 3'd4);

    assign accept   = bus.in_valid && bus.in_ready;
    assign pop      = bus.out_valid && bus.out_ready;
    assign pop_last = pop && (idx_q == 3'd4);

    // Accept and final pop always target different buffers, so set and clear never collide.
    always_comb begin
        full_nxt = full_q;
        if (pop_last) begin
            full_nxt[rd_ptr_q] = 1'b0;
        end
        if (accept) begin
            full_nxt[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            idx_q    <= 3'd0;
        end else begin
            full_q <= full_nxt;
            if (accept) begin
                wr_ptr_q <= !wr_ptr_q;
            end
            if (pop_last) begin
                idx_q    <= 3'd0;
                rd_ptr_q <= !rd_ptr_q;
            end else if (pop) begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    // Frame storage is qualified by the full bits, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_q[wr_ptr_q][0] <= bus.in1;
            frame_q[wr_ptr_q][1] <= bus.in2;
            frame_q[wr_ptr_q][2] <= bus.in3;
            frame_q[wr_ptr_q][3] <= bus.in4;
            frame_q[wr_ptr_q][4] <= bus.in5;
        end
    end

`ifdef SORT_ORDER_CHECK_EN
    logic order_err_q;
    logic order_bad;

    assign order_bad = (bus.in1 < bus.in2) || (bus.in2 < bus.in3) ||
                       (bus.in3 < bus.in4) || (bus.in4 < bus.in5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_err_q <= 1'b0;
        end else if (accept && order_bad) begin
            order_err_q <= 1'b1;
        end
    end

    assign bus.order_err = order_err_q;
`else
    assign bus.order_err = 1'b0;
`endif
endmodule

// File: tb/tb_sort_serializer.sv
// tb/tb_sort_serializer.sv - directed self-checking bench for sort_serializer
module tb_sort_serializer;
`ifdef SORT_ORDER_CHECK_EN
    localparam logic ORDER_EN = 1'b1;
`else
    localparam logic ORDER_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sort_serializer_if #(.WIDTH(16)) bus ();
    sort_serializer #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q [$];
    int exp_idx = 0;
    int pop_cnt = 0;
    int acc_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    initial begin
        logic        hold_v;
        logic [15:0] hold_d;
        logic [2:0]  hold_i;
        logic [15:0] w;
        hold_v = 1'b0;
        hold_d = '0;
        hold_i = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_data", bus.out_data, hold_d);
                    check("hold_idx", bus.out_idx, hold_i);
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(bus.in1);
                    exp_q.push_back(bus.in2);
                    exp_q.push_back(bus.in3);
                    exp_q.push_back(bus.in4);
                    exp_q.push_back(bus.in5);
                    acc_cnt++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("pop_unexpected", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check("sb_data", bus.out_data, w);
                    end
                    check("sb_idx", bus.out_idx, exp_idx);
                    check("sb_last", bus.out_last, (exp_idx == 4));
                    exp_idx = (exp_idx + 1) % 5;
                    pop_cnt++;
                end
                hold_v = bus.out_valid && !bus.out_ready;
                hold_d = bus.out_data;
                hold_i = bus.out_idx;
            end
        end
    end

    task automatic set_frame(input logic [15:0] a, b, c, d, e);
        bus.in1 = a; bus.in2 = b; bus.in3 = c; bus.in4 = d; bus.in5 = e;
        bus.in_valid = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_frame(input logic [15:0] a, b, c, d, e);
        int   n;
        logic r;
        n = 0;
        r = 1'b0;
        set_frame(a, b, c, d, e);
        while (!r && n < 200) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            n++;
        end
        #1;
        check("send_accepted", r, 1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_idle"}, bus.out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] t1 [5];
        int a0, p0;
        t1 = '{16'h9000, 16'h7000, 16'h5000, 16'h3000, 16'h1000};
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in1 = '0; bus.in2 = '0; bus.in3 = '0; bus.in4 = '0; bus.in5 = '0;

        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_order_err", bus.order_err, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // Single frame, consumer always ready
        bus.out_ready = 1'b1;
        send_frame(t1[0], t1[1], t1[2], t1[3], t1[4]);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t1_valid", bus.out_valid, 1);
            check("t1_data", bus.out_data, t1[i]);
            check("t1_idx", bus.out_idx, i);
            check("t1_last", bus.out_last, (i == 4));
        end
        @(negedge clk);
        check("t1_done", bus.out_valid, 0);
        @(posedge clk); #1;

        // Two frames fill both buffers; third is held until A's last word pops
        bus.out_ready = 1'b0;
        set_frame(16'hA004, 16'hA003, 16'hA002, 16'hA001, 16'hA000);
        @(negedge clk);
        check("t2_rdy_a", bus.in_ready, 1);
        @(posedge clk); #1;
        set_frame(16'hB004, 16'hB003, 16'hB002, 16'hB001, 16'hB000);
        @(negedge clk);
        check("t2_rdy_b", bus.in_ready, 1);
        check("t2_a0", bus.out_data, 16'hA004);
        @(posedge clk); #1;
        set_frame(16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'hC000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_full", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t2_rdy_drain", bus.in_ready, (i == 5));
            if (i == 5) check("t2_b0_nogap", bus.out_data, 16'hB004);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain("t2_drain");

        // Toggled ready with duplicate words
        bus.out_ready = 1'b0;
        p0 = pop_cnt;
        send_frame(16'hFFFF, 16'h8000, 16'h8000, 16'h0001, 16'h0000);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.out_ready = ~bus.out_ready;
            @(posedge clk); #1;
        end
        check("t3_pops", pop_cnt - p0, 5);
        check("t3_empty", exp_q.size(), 0);
        bus.out_ready = 1'b1;
        drain("t3_drain");

        // Asynchronous reset mid-frame with a second frame buffered
        bus.out_ready = 1'b0;
        send_frame(16'hD004, 16'hD003, 16'hD002, 16'hD001, 16'hD000);
        send_frame(16'hE004, 16'hE003, 16'hE002, 16'hE001, 16'hE000);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("t4_idx2", bus.out_idx, 2);
        check("t4_d2", bus.out_data, 16'hD002);
        check("t4_both_full", bus.in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_valid", bus.out_valid, 0);
        check("t4_rst_data", bus.out_data, 0);
        check("t4_rst_idx", bus.out_idx, 0);
        check("t4_rst_last", bus.out_last, 0);
        exp_q.delete();
        exp_idx = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("t4_rel_ready", bus.in_ready, 1);
        check("t4_rel_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send_frame(16'h0F04, 16'h0F03, 16'h0F02, 16'h0F01, 16'h0F00);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t4_restart_idx", bus.out_idx, 0);
        check("t4_restart_data", bus.out_data, 16'h0F04);
        @(posedge clk); #1;
        drain("t4_drain");

        // Ordering checker
        check("t5_pre", bus.order_err, 0);
        send_frame(16'h0010, 16'h0020, 16'h0005, 16'h0004, 16'h0003);
        bus.in_valid = 1'b0;
        check("t5_set", bus.order_err, ORDER_EN);
        drain("t5_drain");
        send_frame(16'h0050, 16'h0040, 16'h0030, 16'h0020, 16'h0010);
        bus.in_valid = 1'b0;
        drain("t5_drain2");
        check("t5_sticky", bus.order_err, ORDER_EN);

        // Continuous random frames with consumer always ready
        a0 = acc_cnt;
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) begin
            send_frame($urandom, $urandom, $urandom, $urandom, $urandom);
        end
        bus.in_valid = 1'b0;
        drain("t6_drain");
        check("t6_accepts", acc_cnt - a0, 8);
        check("t6_pops", pop_cnt - p0, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
